// File: rtl/mcvideo_pkg.sv
// mcvideo_pkg: shared definitions for the text-mode video blocks.
//   - scan_state_e : sequencer states of text_scanner
//   - CHAR_W       : width of a character code
//   - GLYPH_SIZE   : glyph is GLYPH_SIZE x GLYPH_SIZE dots
//   - min_width()  : counter width helper that never returns 0
package mcvideo_pkg;

    localparam int CHAR_W     = 7;
    localparam int GLYPH_SIZE = 8;
    localparam int GLYPH_W    = 3;
    localparam logic [GLYPH_W-1:0] GLYPH_LAST = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOOKUP,
        ST_EMIT
    } scan_state_e;

    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/text_position_counter.sv
// text_position_counter: screen position of the character cell being drawn.
//   clock, reset_n : clock, async active-low reset
//   clear          : return to column 0, scanline 0
//   advance        : step to the next cell (column first, then scanline)
//   column         : current text column
//   glyph_row      : scanline within the current text row (ROM y)
//   row_base       : VRAM address of column 0 of the current text row
//   last_column    : column is COLUMNS-1
//   last_scanline  : scanline is ROWS*GLYPH_SIZE-1
module text_position_counter
    import mcvideo_pkg::*;
#(
    parameter  int COLUMNS = 32,
    parameter  int ROWS    = 24,
    localparam int ADDR_W  = min_width(COLUMNS * ROWS),
    localparam int COL_W   = min_width(COLUMNS)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               advance,
    output logic [COL_W-1:0]   column,
    output logic [GLYPH_W-1:0] glyph_row,
    output logic [ADDR_W-1:0]  row_base,
    output logic               last_column,
    output logic               last_scanline
);

    localparam int LINE_W = min_width(ROWS * GLYPH_SIZE);

    logic [COL_W-1:0]  column_q, column_d;
    logic [LINE_W-1:0] scanline_q, scanline_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    assign last_column   = (column_q == COL_W'(COLUMNS - 1));
    assign last_scanline = (scanline_q == LINE_W'(ROWS * GLYPH_SIZE - 1));

    always_comb begin
        column_d   = column_q;
        scanline_d = scanline_q;
        row_base_d = row_base_q;
        if (clear) begin
            column_d   = '0;
            scanline_d = '0;
            row_base_d = '0;
        end else if (advance) begin
            if (!last_column) begin
                column_d = column_q + 1'b1;
            end else begin
                column_d = '0;
                if (!last_scanline) begin
                    scanline_d = scanline_q + 1'b1;
                    // Leaving glyph row 7 means entering the next text row:
                    // the row base moves by one row of cells, no multiply.
                    if (scanline_q[GLYPH_W-1:0] == GLYPH_LAST)
                        row_base_d = row_base_q + ADDR_W'(COLUMNS);
                end else begin
                    // Frame complete: wrap so the next frame starts at cell 0.
                    scanline_d = '0;
                    row_base_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            column_q   <= '0;
            scanline_q <= '0;
            row_base_q <= '0;
        end else begin
            column_q   <= column_d;
            scanline_q <= scanline_d;
            row_base_q <= row_base_d;
        end
    end

    assign column    = column_q;
    assign glyph_row = scanline_q[GLYPH_W-1:0];
    assign row_base  = row_base_q;

endmodule

// File: rtl/text_scanner.sv
// text_scanner: walks a COLUMNS x ROWS text screen and streams its dots.
//   clock, reset_n          : clock, async active-low reset
//   start / busy            : frame request (taken in IDLE) / frame in progress
//   vram_read/address/data  : cell fetch, data returns one cycle after read
//   rom_x/rom_y/rom_character/rom_dot : character_rom lookup, dot one cycle later
//   pixel_valid/ready/pixel : dot stream handshake
//   line_end / frame_end    : last dot of a scanline / of the frame
module text_scanner
    import mcvideo_pkg::*;
#(
    parameter  int COLUMNS = 32,
    parameter  int ROWS    = 24,
    localparam int ADDR_W  = min_width(COLUMNS * ROWS)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               vram_read,
    output logic [ADDR_W-1:0]  vram_address,
    input  logic [CHAR_W-1:0]  vram_data,
    output logic [GLYPH_W-1:0] rom_x,
    output logic [GLYPH_W-1:0] rom_y,
    output logic [CHAR_W-1:0]  rom_character,
    input  logic               rom_dot,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic               pixel,
    output logic               line_end,
    output logic               frame_end
);

    localparam int COL_W = min_width(COLUMNS);

    scan_state_e        state_q, state_d;
    logic [GLYPH_W-1:0] gx_q, gx_d;
    logic [CHAR_W-1:0]  character_q, character_d;
    logic               busy_q, busy_d;
    logic               vram_read_q, vram_read_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic               line_end_q, line_end_d;
    logic               frame_end_q, frame_end_d;

    logic               pos_clear, pos_advance;
    logic [COL_W-1:0]   column;
    logic [ADDR_W-1:0]  row_base;
    logic               last_column, last_scanline;

    text_position_counter #(
        .COLUMNS (COLUMNS),
        .ROWS    (ROWS)
    ) u_position (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear         (pos_clear),
        .advance       (pos_advance),
        .column        (column),
        .glyph_row     (rom_y),
        .row_base      (row_base),
        .last_column   (last_column),
        .last_scanline (last_scanline)
    );

    always_comb begin
        state_d     = state_q;
        gx_d        = gx_q;
        character_d = character_q;
        pos_clear   = 1'b0;
        pos_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pos_clear = 1'b1;
                    gx_d      = '0;
                end
            end
            ST_FETCH:  state_d = ST_WAIT;
            ST_WAIT: begin
                character_d = vram_data;
                gx_d        = '0;
                state_d     = ST_LOOKUP;
            end
            ST_LOOKUP: state_d = ST_EMIT;
            ST_EMIT: begin
                // Without a handshake everything holds, so the ROM keeps
                // resampling the same inputs and the dot stays stable.
                if (pixel_valid_q && pixel_ready) begin
                    if (gx_q != GLYPH_LAST) begin
                        gx_d    = gx_q + 1'b1;
                        state_d = ST_LOOKUP;
                    end else begin
                        pos_advance = 1'b1;
                        state_d = (last_column && last_scanline) ? ST_IDLE : ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d        = (state_d != ST_IDLE);
        vram_read_d   = (state_d == ST_FETCH);
        pixel_valid_d = (state_d == ST_EMIT);
        // Column only moves when EMIT is left, and gx is already final when
        // entering EMIT, so the current values describe the next dot.
        line_end_d    = pixel_valid_d && (gx_q == GLYPH_LAST) && last_column;
        frame_end_d   = line_end_d && last_scanline;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            gx_q          <= '0;
            character_q   <= '0;
            busy_q        <= 1'b0;
            vram_read_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            gx_q          <= gx_d;
            character_q   <= character_d;
            busy_q        <= busy_d;
            vram_read_q   <= vram_read_d;
            pixel_valid_q <= pixel_valid_d;
            line_end_q    <= line_end_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign busy          = busy_q;
    assign vram_read     = vram_read_q;
    assign vram_address  = row_base + ADDR_W'(column);
    assign rom_x         = gx_q;
    assign rom_character = character_q;
    assign pixel_valid   = pixel_valid_q;
    assign pixel         = rom_dot & pixel_valid_q;
    assign line_end      = line_end_q;
    assign frame_end     = frame_end_q;

endmodule

// File: tb/tb_text_scanner.sv
// tb_text_scanner: directed bench for text_scanner.
//   dut_s : 2 x 1 screen, VRAM = {65, 66}, full-stream and handshake checks
//   dut_d : default 32 x 24 screen, row addressing
//   dut_m : 4 x 3 screen, end-of-frame addressing and markers
module tb_text_scanner;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // ---------------- small instance ----------------
    logic       s_start = 1'b0, s_ready = 1'b1;
    logic       s_busy, s_vram_read, s_pixel_valid, s_pixel, s_line_end, s_frame_end;
    logic [0:0] s_vram_address;
    logic [6:0] s_vram_data = 7'd0;
    logic [2:0] s_rom_x, s_rom_y;
    logic [6:0] s_rom_character;
    logic       s_rom_dot = 1'b0;

    text_scanner #(.COLUMNS(2), .ROWS(1)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(s_start), .busy(s_busy),
        .vram_read(s_vram_read), .vram_address(s_vram_address), .vram_data(s_vram_data),
        .rom_x(s_rom_x), .rom_y(s_rom_y), .rom_character(s_rom_character), .rom_dot(s_rom_dot),
        .pixel_valid(s_pixel_valid), .pixel_ready(s_ready), .pixel(s_pixel),
        .line_end(s_line_end), .frame_end(s_frame_end)
    );

    // ---------------- default instance ----------------
    logic       d_start = 1'b0, d_ready = 1'b1;
    logic       d_busy, d_vram_read, d_pixel_valid, d_pixel, d_line_end, d_frame_end;
    logic [9:0] d_vram_address;
    logic [6:0] d_vram_data = 7'd0;
    logic [2:0] d_rom_x, d_rom_y;
    logic [6:0] d_rom_character;
    logic       d_rom_dot = 1'b0;

    text_scanner dut_d (
        .clock(clock), .reset_n(reset_n), .start(d_start), .busy(d_busy),
        .vram_read(d_vram_read), .vram_address(d_vram_address), .vram_data(d_vram_data),
        .rom_x(d_rom_x), .rom_y(d_rom_y), .rom_character(d_rom_character), .rom_dot(d_rom_dot),
        .pixel_valid(d_pixel_valid), .pixel_ready(d_ready), .pixel(d_pixel),
        .line_end(d_line_end), .frame_end(d_frame_end)
    );

    // ---------------- medium instance ----------------
    logic       m_start = 1'b0, m_ready = 1'b1;
    logic       m_busy, m_vram_read, m_pixel_valid, m_pixel, m_line_end, m_frame_end;
    logic [3:0] m_vram_address;
    logic [6:0] m_vram_data = 7'd0;
    logic [2:0] m_rom_x, m_rom_y;
    logic [6:0] m_rom_character;
    logic       m_rom_dot = 1'b0;

    text_scanner #(.COLUMNS(4), .ROWS(3)) dut_m (
        .clock(clock), .reset_n(reset_n), .start(m_start), .busy(m_busy),
        .vram_read(m_vram_read), .vram_address(m_vram_address), .vram_data(m_vram_data),
        .rom_x(m_rom_x), .rom_y(m_rom_y), .rom_character(m_rom_character), .rom_dot(m_rom_dot),
        .pixel_valid(m_pixel_valid), .pixel_ready(m_ready), .pixel(m_pixel),
        .line_end(m_line_end), .frame_end(m_frame_end)
    );

    // Glyph ROM contents: 'A' and 'B' hand drawn, other codes filler.
    function automatic logic glyph_dot(input logic [6:0] ch, input logic [2:0] y, input logic [2:0] x);
        logic [7:0] row;
        case (ch)
            7'd65: case (y)
                3'd0: row = 8'h18; 3'd1: row = 8'h24; 3'd2: row = 8'h42; 3'd3: row = 8'h42;
                3'd4: row = 8'h7E; 3'd5: row = 8'h42; 3'd6: row = 8'h42; default: row = 8'h00;
            endcase
            7'd66: case (y)
                3'd0: row = 8'h7C; 3'd1: row = 8'h42; 3'd2: row = 8'h42; 3'd3: row = 8'h7C;
                3'd4: row = 8'h42; 3'd5: row = 8'h42; 3'd6: row = 8'h7C; default: row = 8'h00;
            endcase
            default: row = {1'b0, ch} ^ {y, 5'd0};
        endcase
        return row[3'd7 - x];
    endfunction

    // Expected 2x1 screen "AB", one 16-dot scanline per entry, MSB first.
    logic [15:0] gold [8] = '{16'h187C, 16'h2442, 16'h4242, 16'h427C,
                              16'h7E42, 16'h4242, 16'h427C, 16'h0000};

    // VRAM and ROM models: one-cycle latency each.
    always @(posedge clock) begin
        if (s_vram_read) s_vram_data <= (s_vram_address == 1'b0) ? 7'd65 : 7'd66;
        if (d_vram_read) d_vram_data <= d_vram_address[6:0];
        if (m_vram_read) m_vram_data <= {3'd0, m_vram_address};
        s_rom_dot <= glyph_dot(s_rom_character, s_rom_y, s_rom_x);
        d_rom_dot <= glyph_dot(d_rom_character, d_rom_y, d_rom_x);
        m_rom_dot <= glyph_dot(m_rom_character, m_rom_y, m_rom_x);
    end

    // Transaction recorders.
    bit s_pix [$];
    bit s_le [$];
    bit s_fe [$];
    int s_hs_cyc [$];
    int s_fetch_addr [$];
    int s_fetch_cyc [$];
    bit ref_pix [$];
    int d_fetch_addr [$];
    int m_npix = 0, m_nle = 0, m_nfe = 0, m_fe_idx = -1, m_nfetch = 0, m_last_addr = -1;

    always @(posedge clock) begin
        if (s_pixel_valid && s_ready) begin
            s_pix.push_back(s_pixel);
            s_le.push_back(s_line_end);
            s_fe.push_back(s_frame_end);
            s_hs_cyc.push_back(cyc);
        end
        if (s_vram_read) begin
            s_fetch_addr.push_back(int'(s_vram_address));
            s_fetch_cyc.push_back(cyc);
        end
        if (d_vram_read) d_fetch_addr.push_back(int'(d_vram_address));
        if (m_pixel_valid && m_ready) begin
            m_npix++;
            if (m_line_end) m_nle++;
            if (m_frame_end) begin
                m_nfe++;
                m_fe_idx = m_npix;
            end
        end
        if (m_vram_read) begin
            m_nfetch++;
            m_last_addr = int'(m_vram_address);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_s();
        s_pix.delete(); s_le.delete(); s_fe.delete(); s_hs_cyc.delete();
        s_fetch_addr.delete(); s_fetch_cyc.delete();
    endtask

    task automatic wait_idle_s(input int limit, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (!s_busy) begin
                at_cyc = cyc;
                return;
            end
        end
    endtask

    task automatic wait_pix_s(input int n, input bit need_valid, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (s_pix.size() >= n && (s_pixel_valid || !need_valid)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_frame(input string tag, input bit timing);
        logic [15:0] row;
        check({tag, "_npix"}, s_pix.size(), 128);
        check({tag, "_nfetch"}, s_fetch_addr.size(), 16);
        for (int p = 0; p < 128 && p < s_pix.size(); p++) begin
            row = gold[p / 16];
            check($sformatf("%s_pix%0d", tag, p), s_pix[p], row[15 - (p % 16)]);
            check($sformatf("%s_le%0d", tag, p), s_le[p], (p % 16) == 15);
            check($sformatf("%s_fe%0d", tag, p), s_fe[p], p == 127);
        end
        for (int i = 0; i < s_fetch_addr.size(); i++) begin
            check($sformatf("%s_faddr%0d", tag, i), s_fetch_addr[i], i % 2);
            if (timing && i > 0)
                check($sformatf("%s_fgap%0d", tag, i), s_fetch_cyc[i] - s_fetch_cyc[i-1], 18);
        end
    endtask

    initial begin
        int t0, tend;
        bit ok;
        logic snap_pix, snap_le;
        logic [2:0] snap_x, snap_y;
        logic [6:0] snap_c;

        // Reset state.
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outs_s", {s_busy, s_vram_read, s_vram_address, s_rom_x, s_rom_y, s_rom_character,
                               s_pixel_valid, s_pixel, s_line_end, s_frame_end}, 0);
        check("reset_outs_d", {d_busy, d_vram_read, d_vram_address, d_pixel_valid, d_line_end, d_frame_end}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Frame 1: latency, full stream, cell timing, busy fall.
        clear_s();
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        t0 = cyc;
        check("c1_vram_read", s_vram_read, 1);
        check("c1_addr", s_vram_address, 0);
        check("c1_busy", s_busy, 1);
        @(negedge clock);
        check("c2_vram_read", s_vram_read, 0);
        check("c2_valid", s_pixel_valid, 0);
        @(negedge clock);
        check("c3_valid", s_pixel_valid, 0);
        check("c3_char", s_rom_character, 65);
        @(negedge clock);
        check("c4_valid", s_pixel_valid, 1);
        check("c4_pixel", s_pixel, 0);
        check("c4_rom_xy", {s_rom_x, s_rom_y}, 0);
        wait_idle_s(2000, tend);
        check("f1_done", tend != -1, 1);
        check_frame("f1", 1'b1);
        if (s_hs_cyc.size() > 0) check("f1_busy_fall", tend, s_hs_cyc[$] + 1);
        check("f1_len", tend - t0 + 1, 2 * 1 * 8 * 18 + 1);
        ref_pix = s_pix;

        // Frame 2: stall mid-glyph, start pulsed while busy.
        clear_s();
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        wait_pix_s(37, 1'b1, ok);
        check("bp_reach", ok, 1);
        s_ready = 1'b0;
        check("bp_mid_glyph_x", s_rom_x, 5);
        snap_pix = s_pixel; snap_le = s_line_end;
        snap_x = s_rom_x; snap_y = s_rom_y; snap_c = s_rom_character;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("bp_hold%0d", i),
                  {s_pixel_valid, s_pixel, s_line_end, s_rom_x, s_rom_y, s_rom_character},
                  {1'b1, snap_pix, snap_le, snap_x, snap_y, snap_c});
            check($sformatf("bp_nohs%0d", i), s_pix.size(), 37);
        end
        s_ready = 1'b1;
        wait_pix_s(80, 1'b0, ok);
        check("busy_start_reach", ok, 1);
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        wait_idle_s(2000, tend);
        check("f2_done", tend != -1, 1);
        // Start immediately in the first idle cycle after the last handshake.
        s_start = 1'b1;
        check_frame("f2", 1'b0);
        check("f2_same_as_f1", s_pix == ref_pix, 1);
        clear_s();
        @(negedge clock);
        s_start = 1'b0;
        check("f3_restart_read", s_vram_read, 1);
        check("f3_restart_addr", s_vram_address, 0);

        // Frame 3: asynchronous reset at pixel 40.
        wait_pix_s(40, 1'b0, ok);
        check("rst_reach", ok, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_outs", {s_busy, s_vram_read, s_vram_address, s_rom_x, s_rom_y, s_rom_character,
                                 s_pixel_valid, s_pixel, s_line_end, s_frame_end}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        clear_s();
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        check("f4_read", s_vram_read, 1);
        check("f4_addr", s_vram_address, 0);
        repeat (2) @(negedge clock);
        check("f4_lookup", {s_rom_y, s_rom_x, s_rom_character}, {3'd0, 3'd0, 7'd65});
        wait_idle_s(2000, tend);
        check("f4_done", tend != -1, 1);
        check_frame("f4", 1'b1);

        // Default and 4x3 screens.
        d_fetch_addr.delete();
        d_start = 1'b1;
        m_start = 1'b1;
        @(negedge clock);
        d_start = 1'b0;
        m_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            if (!m_busy) ok = 1'b1;
        end
        check("m_done", ok, 1);
        check("m_nfetch", m_nfetch, 96);
        check("m_last_addr", m_last_addr, 11);
        check("m_npix", m_npix, 768);
        check("m_nline_end", m_nle, 24);
        check("m_nframe_end", m_nfe, 1);
        check("m_frame_end_pix", m_fe_idx, 768);
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clock);
            if (d_fetch_addr.size() >= 258) ok = 1'b1;
        end
        check("d_reach", ok, 1);
        if (ok) begin
            check("d_sl1_c0", d_fetch_addr[32], 0);
            check("d_sl7_c0", d_fetch_addr[224], 0);
            check("d_sl7_c31", d_fetch_addr[255], 31);
            check("d_sl8_c0", d_fetch_addr[256], 32);
            check("d_sl8_c1", d_fetch_addr[257], 33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_scanner.md
# text_scanner

Sequencer that drives `character_rom` to render a full text screen as a serial pixel stream. It sits between the video RAM holding 7-bit character codes and the pixel sink (video timing / frame buffer writer). Each frame it walks every scanline, fetches each cell's character code, and steps the ROM through the glyph row. It emits one dot per pixel under a valid/ready handshake.

## Interface
Parameters:
- `COLUMNS`, default 32: characters per text row.
- `ROWS`, default 24: text rows per frame.
- Derived localparam `ADDR_W` = clog2(COLUMNS*ROWS).

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to render one frame; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle after the final pixel handshake.
- `vram_read` out 1: VRAM read strobe.
- `vram_address` out ADDR_W: cell address, row*COLUMNS + column.
- `vram_data` in 7: character code, valid exactly one cycle after `vram_read`.
- `rom_x`, `rom_y` out 3: glyph column and glyph row to `character_rom`.
- `rom_character` out 7: character code to `character_rom`.
- `rom_dot` in 1: `character_rom` output, valid one cycle after its inputs are sampled.
- `pixel_valid` out 1: pixel available.
- `pixel_ready` in 1: sink accepts the pixel.
- `pixel` out 1: dot value, equal to `rom_dot & pixel_valid`.
- `line_end` out 1: qualifies the last pixel of a scanline.
- `frame_end` out 1: qualifies the last pixel of a frame.

## Operation
- Reset values: every output is 0 and the state is IDLE.
- Counters: `column` (0..COLUMNS-1), `scanline` (0..ROWS*8-1), `gx` (0..7).
  - Text row = scanline[.. :3].
  - `rom_y` = scanline[2:0].
- States:
  - IDLE: `start` leads to FETCH; `busy` rises and all counters clear.
  - FETCH: `vram_read`=1 for one cycle with `vram_address` = row_base + column. Next state is WAIT.
  - WAIT: latch `vram_data` into `rom_character` and set `gx`=0. Next state is LOOKUP.
  - LOOKUP: `rom_x`=gx; the ROM samples its inputs at this edge. Next state is EMIT.
  - EMIT: `pixel_valid`=1 and the ROM inputs are held. On `pixel_valid & pixel_ready`:
    - if gx<7: gx+1, go to LOOKUP;
    - else if column<COLUMNS-1: column+1, go to FETCH;
    - else if scanline<ROWS*8-1: column=0, scanline+1, go to FETCH;
    - else go to IDLE.
- `row_base` is maintained incrementally and advances by COLUMNS when scanline[2:0] wraps from 7 to 0. No multiplier is used.
- `line_end` is high during EMIT when gx=7 and column=COLUMNS-1. `frame_end` is additionally conditioned on the last scanline. Both are meaningful only while `pixel_valid`.
- `start` is ignored while `busy`.
- A `start` in the cycle after the final handshake (state IDLE) is accepted normally.
- Asserting `reset_n` low mid-frame immediately forces IDLE and the reset output values. The next `start` begins at address 0, scanline 0.

## Timing
- With `start` high at edge 0: FETCH at cycle 1, WAIT at cycle 2, LOOKUP at cycle 3, first `pixel_valid` at cycle 4.
- With `pixel_ready` held high:
  - 18 cycles per character cell (FETCH, WAIT, 8 × LOOKUP/EMIT).
  - Frame length is COLUMNS*ROWS*8*18 cycles plus 1.
- Backpressure: while `pixel_valid & !pixel_ready`, the state, `pixel`, all `rom_*` outputs, `line_end` and `frame_end` stay stable. No pixel is dropped or duplicated.
- `busy` falls one cycle after the `frame_end` handshake.

## Structure
- Shared package `mcvideo_pkg` holds:
  - the state enum (IDLE, FETCH, WAIT, LOOKUP, EMIT);
  - CHAR_W=7 and GLYPH_SIZE=8.
- Sub-module `text_position_counter` holds `column`, `scanline` and `row_base`, with an advance input and `last_column` / `last_scanline` flags. The FSM stays in `text_scanner`.

## Test plan
- Reset: hold `reset_n`=0 → all outputs 0. Then pulse `start` with COLUMNS=2, ROWS=1 → `vram_read`=1, address 0 at cycle 1; first `pixel_valid` at cycle 4.
- Full frame, ready high, VRAM={65,66}, ROM model returns known 'A'/'B' glyphs:
  - 128 pixels match the golden bitmap;
  - `line_end` on pixels 16, 32, …, 128;
  - `frame_end` only on pixel 128;
  - 18 cycles per cell;
  - `busy` low one cycle after the last pixel.
- Backpressure: drop `pixel_ready` for 5 cycles mid-glyph → `pixel`, `rom_x`, `rom_y` and `rom_character` are stable, and the output stream is identical to the no-stall run.
- `start` pulsed while busy → ignored (no restart, no extra frame). `start` in the cycle after the final handshake → a new frame starts at address 0.
- `reset_n` asserted asynchronously at pixel 40 → outputs 0 before the next edge. A subsequent `start` restarts at scanline 0, address 0.
- Defaults COLUMNS=32, ROWS=24:
  - scanline 8, column 0 fetches address 32;
  - the final fetch is address 767;
  - `frame_end` falls on pixel 49152.
